// File: rtl/id_exe_reg_pkg.sv
// Shared definitions for the ID/EXE pipeline register: datapath width,
// ALU command encodings, control-field bundle and the bubble counter helper.
package id_exe_reg_pkg;

  localparam int WORD_W_DEF = 32;

  localparam int EXE_CMD_W  = 4;
  localparam int REG_IDX_W  = 4;
  localparam int SR_W       = 4;
  localparam int SHOP_W     = 12;
  localparam int SIMM_W     = 24;
  localparam int BUBBLE_W   = 16;

  typedef enum logic [EXE_CMD_W-1:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // Compare, test and memory address generation reuse existing ALU ops.
  localparam exe_cmd_e EXE_CMP = EXE_SUB;
  localparam exe_cmd_e EXE_TST = EXE_AND;
  localparam exe_cmd_e EXE_LDR = EXE_ADD;
  localparam exe_cmd_e EXE_STR = EXE_ADD;

  typedef struct packed {
    logic                 wb_en;
    logic                 mem_r_en;
    logic                 mem_w_en;
    logic                 b;
    logic                 s;
    logic [EXE_CMD_W-1:0] exe_cmd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    logic              imm;
    logic [SHOP_W-1:0] shifter_operand;
    logic [SIMM_W-1:0] signed_imm_24;
  } shifter_t;

  localparam int SHIFTER_W = $bits(shifter_t);

  typedef struct packed {
    logic [REG_IDX_W-1:0] dest;
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
  } reg_idx_t;

  localparam int REG_IDX_GRP_W = $bits(reg_idx_t);

  // Saturating increment; the counter sticks at all-ones rather than wrapping.
  function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
    logic [BUBBLE_W-1:0] r;
    r = v;
    if (v != {BUBBLE_W{1'b1}}) begin
      r = v + {{(BUBBLE_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/id_exe_reg_pipe_field_reg.sv
// One field group of a pipeline register: async active-low reset to zero,
// flush clears, freeze holds, otherwise loads the incoming value.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         freeze,
  input  logic         flush,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Flush beats freeze so a taken branch can squash a stalled instruction.
  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = '0;
    end else if (!freeze) begin
      data_d = d_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_out = data_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: carries decoded control, operands and register
// indices into execute, with stall hold, branch flush and a bubble counter.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeze,
  input  logic                 flush,

  input  logic                 wb_en_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic                 b_in,
  input  logic                 s_in,
  input  logic [3:0]           exe_cmd_in,
  input  logic [WORD_W-1:0]    pc_in,
  input  logic [WORD_W-1:0]    val_rn_in,
  input  logic [WORD_W-1:0]    val_rm_in,
  input  logic                 imm_in,
  input  logic [11:0]          shifter_operand_in,
  input  logic [23:0]          signed_imm_24_in,
  input  logic [3:0]           dest_in,
  input  logic [3:0]           src1_in,
  input  logic [3:0]           src2_in,
  input  logic [3:0]           sr_in,

  output logic                 wb_en_out,
  output logic                 mem_r_en_out,
  output logic                 mem_w_en_out,
  output logic                 b_out,
  output logic                 s_out,
  output logic [3:0]           exe_cmd_out,
  output logic [WORD_W-1:0]    pc_out,
  output logic [WORD_W-1:0]    val_rn_out,
  output logic [WORD_W-1:0]    val_rm_out,
  output logic                 imm_out,
  output logic [11:0]          shifter_operand_out,
  output logic [23:0]          signed_imm_24_out,
  output logic [3:0]           dest_out,
  output logic [3:0]           src1_out,
  output logic [3:0]           src2_out,
  output logic [3:0]           sr_out,
  output logic                 valid_out,
  output logic [15:0]          bubble_cnt
);

  localparam int OPND_W = 3 * WORD_W;

  // ---------------------------------------------------------------------------
  // Field group packing
  // ---------------------------------------------------------------------------
  ctrl_t                ctrl_in;
  ctrl_t                ctrl_out;
  logic [OPND_W-1:0]    opnd_in;
  logic [OPND_W-1:0]    opnd_out;
  shifter_t             shf_in;
  shifter_t             shf_out;
  reg_idx_t             idx_in;
  reg_idx_t             idx_out;
  logic [SR_W-1:0]      sr_q_out;
  logic                 valid_q_out;

  always_comb begin
    ctrl_in          = '0;
    ctrl_in.wb_en    = wb_en_in;
    ctrl_in.mem_r_en = mem_r_en_in;
    ctrl_in.mem_w_en = mem_w_en_in;
    ctrl_in.b        = b_in;
    ctrl_in.s        = s_in;
    ctrl_in.exe_cmd  = exe_cmd_in;
  end

  assign opnd_in = {pc_in, val_rn_in, val_rm_in};

  // The shifter operand is an opaque ARM encoding; execute decodes it.
  always_comb begin
    shf_in                 = '0;
    shf_in.imm             = imm_in;
    shf_in.shifter_operand = shifter_operand_in;
    shf_in.signed_imm_24   = signed_imm_24_in;
  end

  always_comb begin
    idx_in      = '0;
    idx_in.dest = dest_in;
    idx_in.src1 = src1_in;
    idx_in.src2 = src2_in;
  end

  // ---------------------------------------------------------------------------
  // Field group registers
  // ---------------------------------------------------------------------------
  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .d_in   (ctrl_in),
    .q_out  (ctrl_out)
  );

  pipe_field_reg #(.W(OPND_W)) u_opnd_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .d_in   (opnd_in),
    .q_out  (opnd_out)
  );

  pipe_field_reg #(.W(SHIFTER_W)) u_shf_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .d_in   (shf_in),
    .q_out  (shf_out)
  );

  // Register indices stay visible while frozen so forwarding can still
  // match against the stalled instruction's sources.
  pipe_field_reg #(.W(REG_IDX_GRP_W)) u_idx_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .d_in   (idx_in),
    .q_out  (idx_out)
  );

  pipe_field_reg #(.W(SR_W)) u_sr_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .d_in   (sr_in),
    .q_out  (sr_q_out)
  );

  // A normal load always brings in a real instruction; flush turns it into a bubble.
  pipe_field_reg #(.W(1)) u_valid_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .d_in   (1'b1),
    .q_out  (valid_q_out)
  );

  // ---------------------------------------------------------------------------
  // Bubble counter
  // ---------------------------------------------------------------------------
  logic [BUBBLE_W-1:0] bubble_cnt_q;
  logic [BUBBLE_W-1:0] bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------------
  assign wb_en_out           = ctrl_out.wb_en;
  assign mem_r_en_out        = ctrl_out.mem_r_en;
  assign mem_w_en_out        = ctrl_out.mem_w_en;
  assign b_out               = ctrl_out.b;
  assign s_out               = ctrl_out.s;
  assign exe_cmd_out         = ctrl_out.exe_cmd;
  assign pc_out              = opnd_out[OPND_W-1 -: WORD_W];
  assign val_rn_out          = opnd_out[2*WORD_W-1 -: WORD_W];
  assign val_rm_out          = opnd_out[WORD_W-1:0];
  assign imm_out             = shf_out.imm;
  assign shifter_operand_out = shf_out.shifter_operand;
  assign signed_imm_24_out   = shf_out.signed_imm_24;
  assign dest_out            = idx_out.dest;
  assign src1_out            = idx_out.src1;
  assign src2_out            = idx_out.src2;
  assign sr_out              = sr_q_out;
  assign valid_out           = valid_q_out;
  assign bubble_cnt          = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: reset, load, freeze, flush, async reset,
// back-to-back loads, a short modelled random stream and counter saturation.
module tb_id_exe_reg;

  localparam int W    = 32;
  localparam int IN_W = 158;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic freeze = 1'b0;
  logic flush  = 1'b0;

  always #5 clk = ~clk;

  logic [IN_W-1:0] in_vec = '0;
  logic [IN_W-1:0] out_vec;

  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
  logic [W-1:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shifter_operand_in;
  logic [23:0] signed_imm_24_in;

  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
  logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
  logic [W-1:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shifter_operand_out;
  logic [23:0] signed_imm_24_out;
  logic        valid_out;
  logic [15:0] bubble_cnt;

  assign {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
          pc_in, val_rn_in, val_rm_in, imm_in, shifter_operand_in,
          signed_imm_24_in, dest_in, src1_in, src2_in, sr_in} = in_vec;

  assign out_vec = {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out,
                    pc_out, val_rn_out, val_rm_out, imm_out, shifter_operand_out,
                    signed_imm_24_out, dest_out, src1_out, src2_out, sr_out};

  id_exe_reg #(.WORD_W(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .freeze              (freeze),
    .flush               (flush),
    .wb_en_in            (wb_en_in),
    .mem_r_en_in         (mem_r_en_in),
    .mem_w_en_in         (mem_w_en_in),
    .b_in                (b_in),
    .s_in                (s_in),
    .exe_cmd_in          (exe_cmd_in),
    .pc_in               (pc_in),
    .val_rn_in           (val_rn_in),
    .val_rm_in           (val_rm_in),
    .imm_in              (imm_in),
    .shifter_operand_in  (shifter_operand_in),
    .signed_imm_24_in    (signed_imm_24_in),
    .dest_in             (dest_in),
    .src1_in             (src1_in),
    .src2_in             (src2_in),
    .sr_in               (sr_in),
    .wb_en_out           (wb_en_out),
    .mem_r_en_out        (mem_r_en_out),
    .mem_w_en_out        (mem_w_en_out),
    .b_out               (b_out),
    .s_out               (s_out),
    .exe_cmd_out         (exe_cmd_out),
    .pc_out              (pc_out),
    .val_rn_out          (val_rn_out),
    .val_rm_out          (val_rm_out),
    .imm_out             (imm_out),
    .shifter_operand_out (shifter_operand_out),
    .signed_imm_24_out   (signed_imm_24_out),
    .dest_out            (dest_out),
    .src1_out            (src1_out),
    .src2_out            (src2_out),
    .sr_out              (sr_out),
    .valid_out           (valid_out),
    .bubble_cnt          (bubble_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Vectors laid out as {wb,mr,mw,b,s,cmd, pc,rn,rm, imm,shop,simm24, dest,src1,src2, sr}
  localparam logic [IN_W-1:0] VEC_LOAD = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010,
    32'h0000_0014, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 12'h1E3, 24'h00_0000,
    4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [IN_W-1:0] VEC_FRZ = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0101,
    32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b1, 12'hABC, 24'h12_3456,
    4'h3, 4'h4, 4'h5, 4'h9};
  localparam logic [IN_W-1:0] VEC_STR = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010,
    32'h0000_0100, 32'h0000_2000, 32'hCAFE_F00D, 1'b1, 12'h0FF, 24'hFF_FFFE,
    4'hE, 4'h1, 4'h2, 4'h2};

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario tasks
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    in_vec = VEC_LOAD;
    repeat (2) step();
    vectors++;
    if (out_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: got %h want 0", out_vec);
    end
    vectors++;
    if (valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    vectors++;
    if (bubble_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_bubble: got %h want 0", bubble_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    in_vec = VEC_LOAD;
    step();
    vectors++;
    if (out_vec !== VEC_LOAD) begin
      miscompares++;
      $display("FAIL load_fields: got %h want %h", out_vec, VEC_LOAD);
    end
    vectors++;
    if (valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL load_valid: got %b want 1", valid_out);
    end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    in_vec = VEC_FRZ;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_vec !== VEC_LOAD || valid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL freeze_hold[%0d]: got %h/%b want %h/1", i, out_vec, valid_out, VEC_LOAD);
      end
      vectors++;
      if (bubble_cnt !== 16'h0) begin
        miscompares++;
        $display("FAIL freeze_bubble[%0d]: got %h want 0", i, bubble_cnt);
      end
    end
    freeze = 1'b0;
    step();
    vectors++;
    if (out_vec !== VEC_FRZ) begin
      miscompares++;
      $display("FAIL freeze_release: got %h want %h", out_vec, VEC_FRZ);
    end
  endtask

  task automatic test_flush_freeze();
    in_vec = VEC_STR;
    flush  = 1'b1;
    freeze = 1'b1;
    step();
    flush  = 1'b0;
    freeze = 1'b0;
    vectors++;
    if (mem_w_en_out !== 1'b0 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ctrl: got mw=%b v=%b want 0/0", mem_w_en_out, valid_out);
    end
    vectors++;
    if (out_vec !== '0) begin
      miscompares++;
      $display("FAIL flush_fields: got %h want 0", out_vec);
    end
    vectors++;
    if (bubble_cnt !== 16'h1) begin
      miscompares++;
      $display("FAIL flush_bubble: got %h want 1", bubble_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [IN_W-1:0] seq [3];
    seq[0] = VEC_STR;
    seq[1] = VEC_LOAD;
    seq[2] = VEC_FRZ;
    for (int i = 0; i < 3; i++) begin
      in_vec = seq[i];
      step();
      vectors++;
      if (out_vec !== seq[i] || valid_out !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got %h/%b want %h/1", i, out_vec, valid_out, seq[i]);
      end
    end
    // Flush alone right after a load, then reload
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (valid_out !== 1'b0 || bubble_cnt !== 16'h2) begin
      miscompares++;
      $display("FAIL b2b_flush: got v=%b cnt=%h want 0/2", valid_out, bubble_cnt);
    end
    in_vec = VEC_STR;
    step();
    vectors++;
    if (out_vec !== VEC_STR || valid_out !== 1'b1 || bubble_cnt !== 16'h2) begin
      miscompares++;
      $display("FAIL b2b_reload: got %h/%b/%h want %h/1/2", out_vec, valid_out, bubble_cnt, VEC_STR);
    end
  endtask

  task automatic test_async_reset();
    // Mid-cycle assertion: outputs clear with no clock edge
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_vec !== '0 || valid_out !== 1'b0 || bubble_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h/%b/%h want 0/0/0", out_vec, valid_out, bubble_cnt);
    end
    // Reset held across an edge with flush and freeze both asserted
    flush  = 1'b1;
    freeze = 1'b1;
    in_vec = VEC_LOAD;
    step();
    vectors++;
    if (out_vec !== '0 || valid_out !== 1'b0 || bubble_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_override: got %h/%b/%h want 0/0/0", out_vec, valid_out, bubble_cnt);
    end
    flush  = 1'b0;
    freeze = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    vectors++;
    if (out_vec !== VEC_LOAD || valid_out !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_load: got %h/%b want %h/1", out_vec, valid_out, VEC_LOAD);
    end
  endtask

  task automatic test_random();
    logic [IN_W-1:0] exp_q[$];
    logic [IN_W-1:0] exp_vec;
    logic            exp_valid;
    logic [15:0]     exp_cnt;
    logic [159:0]    r;
    rst_n = 1'b0;
    #1;
    rst_n     = 1'b1;
    exp_vec   = '0;
    exp_valid = 1'b0;
    exp_cnt   = 16'h0;
    for (int i = 0; i < 400; i++) begin
      r      = {$urandom, $urandom, $urandom, $urandom, $urandom};
      in_vec = r[IN_W-1:0];
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      if (flush) begin
        exp_vec   = '0;
        exp_valid = 1'b0;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end else if (!freeze) begin
        exp_vec   = in_vec;
        exp_valid = 1'b1;
      end
      exp_q.push_back(exp_vec);
      step();
      exp_vec = exp_q.pop_front();
      vectors++;
      if (out_vec !== exp_vec || valid_out !== exp_valid || bubble_cnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h/%b/%h want %h/%b/%h", i, out_vec, valid_out,
                 bubble_cnt, exp_vec, exp_valid, exp_cnt);
      end
    end
    flush  = 1'b0;
    freeze = 1'b0;
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    vectors++;
    if (bubble_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_preload: got %h want fffe", bubble_cnt);
    end
    step();
    vectors++;
    if (bubble_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_reach: got %h want ffff", bubble_cnt);
    end
    step();
    vectors++;
    if (bubble_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got %h want ffff", bubble_cnt);
    end
    flush = 1'b0;
    in_vec = VEC_LOAD;
    step();
    vectors++;
    if (bubble_cnt !== 16'hFFFF || out_vec !== VEC_LOAD) begin
      miscompares++;
      $display("FAIL sat_after_load: got %h/%h want ffff/%h", bubble_cnt, out_vec, VEC_LOAD);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_load();
    test_freeze();
    test_flush_freeze();
    test_back_to_back();
    test_async_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter WORD_W, 32, datapath width of PC, Rn and Rm values.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 freeze  in  1  hazard stall; hold all stored fields.
REQ-005 flush  in  1  taken branch; load a bubble.
REQ-006 wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  ID control bits.
REQ-007 exe_cmd_in  in  4  ALU command.
REQ-008 pc_in, val_rn_in, val_rm_in  in  WORD_W each  PC+4 and register-file values.
REQ-009 imm_in  in  1; shifter_operand_in  in  12; signed_imm_24_in  in  24.
REQ-010 dest_in, src1_in, src2_in  in  4 each  register indices for writeback and forwarding.
REQ-011 sr_in  in  4  NZCV from status register, C used by ADC/SBC.
REQ-012 Each *_in has a matching *_out of equal width; valid_out  out  1  stage holds a real instruction.
REQ-013 bubble_cnt  out  16  count of cycles in which a bubble was loaded.

Function
REQ-014 Priority per rising edge: flush, then freeze, then normal load.
REQ-015 Normal load (flush=0, freeze=0): every *_out takes its *_in, valid_out=1; latency one cycle.
REQ-016 Freeze (flush=0, freeze=1): every *_out and valid_out hold; bubble_cnt holds.
REQ-017 Flush (flush=1, any freeze): wb_en, mem_r_en, mem_w_en, b, s outputs = 0, exe_cmd_out = 0, valid_out = 0; datapath fields (pc, val_rn, val_rm, imm, shifter_operand, signed_imm_24, dest, src1, src2, sr) = 0.
REQ-018 A bubble consumer SHALL rely only on valid_out/control bits; zeroed datapath fields are for waveform clarity only.
REQ-019 bubble_cnt increments by 1 on each flush edge; saturates at 16'hFFFF, no wrap.
REQ-020 src1_out/src2_out SHALL be live during freeze, so forwarding logic sees the stalled instruction's operands.
REQ-021 No combinational path from any input to any output.
REQ-022 shifter_operand_out[11:0] carries ARM encoding unchanged: [7:0] imm8, [11:8] rotate, or [11:7] shift amount, [6:5] shift type; no decoding here.

Reset
REQ-023 rst_n low SHALL immediately (no clock needed) force all *_out, valid_out and bubble_cnt to 0.
REQ-024 rst_n deassertion mid-stream: first rising edge after release performs normal/freeze/flush per REQ-014.
REQ-025 Reset asserted during freeze or flush overrides both.

Structure
REQ-026 Shared package/header holds WORD_W default, exe_cmd encodings (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP/SUB 0100, TST/AND 0110, LDR/STR 0010) and NOP exe_cmd 0000.
REQ-027 One sub-module, pipe_field_reg (parameterised width, async active-low reset, freeze hold, flush clear), instantiated per field group; bubble counter in top.

Verification
REQ-028 rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 before next edge; bubble_cnt=0.
REQ-029 Load pc_in=32'h0000_0014, val_rm_in=32'hDEAD_BEEF, shifter_operand_in=12'h1E3, wb_en_in=1, exe_cmd_in=0010 -> next edge outputs equal inputs, valid_out=1.
REQ-030 freeze=1 for 3 cycles while inputs change to 32'h1234_5678 -> outputs keep prior values, bubble_cnt unchanged; freeze=0 -> new values one edge later.
REQ-031 flush=1 and freeze=1 same edge with mem_w_en_in=1 -> mem_w_en_out=0, valid_out=0, bubble_cnt +1.
REQ-032 Preload bubble_cnt to 16'hFFFE via 65534 flushes (or force), two more flushes -> 16'hFFFF, stays.
REQ-033 Random 10k-cycle freeze/flush/input stream vs reference model -> outputs match every cycle.
